mem_bus_ctrl: RTL and testbench

//  Memory-side bus controller directly downstream of the multicycle datapath.
//  - Takes the datapath's address/store-data request and routes it by region to the unified RAM port or to the IO port.
//  - Returns read data that feeds the datapath memdata input.
//  - Gives the control FSM a one-cycle done pulse, so the FSM stalls for variable-latency accesses.

---
 rtl/mem_bus_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: routes datapath requests to the RAM or IO port and returns a done pulse.
// Optional IO ack timeout is compiled in with `define BUS_TIMEOUT_EN.
module mem_bus_ctrl #(
  parameter int                 WIDTH             = 16,
  parameter logic [WIDTH-1:0]   INSTRUCTION_MEM   = 16'h0000,
  parameter logic [WIDTH-1:0]   INTERRUPT_CONTROL = 16'h5FFF,
  parameter logic [WIDTH-1:0]   IO_MEM            = 16'hCFFD,
  parameter int                 RAM_LAT           = 1,
  parameter int                 TIMEOUT           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] wdata,
  output logic             req_done,
  output logic [WIDTH-1:0] rdata,
  output logic             bus_err,
  output logic             ram_en,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic             io_req,
  output logic             io_we,
  output logic [WIDTH-1:0] io_addr,
  output logic [WIDTH-1:0] io_wdata,
  input  logic [WIDTH-1:0] io_rdata,
  input  logic             io_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAM  = 2'd1,
    IO   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0]       RAM_LAST  = 3'(RAM_LAT - 1);
  localparam logic [WIDTH-1:0] PROT_SPAN = INTERRUPT_CONTROL - INSTRUCTION_MEM;
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};

  if (RAM_LAT < 1 || RAM_LAT > 7 || TIMEOUT < 1) begin : gBadParams
    $error("mem_bus_ctrl: RAM_LAT must be 1..7 and TIMEOUT must be >= 1");
  end

  state_t           stateR;
  state_t           stateNxt;
  logic [WIDTH-1:0] addrR;
  logic [WIDTH-1:0] wdataR;
  logic             writeR;
  logic             errR;
  logic [WIDTH-1:0] rdataR;
  logic [2:0]       ramCntR;
  logic [WIDTH-1:0] protOffset;
  logic             protHit;
  logic             ioHit;
  logic             ramLast;
  logic             toExpire;

  // Offset compare keeps the region test correct even when the region starts at zero.
  assign protOffset = address - INSTRUCTION_MEM;
  assign protHit    = req_write && (protOffset <= PROT_SPAN);
  assign ioHit      = (address >= IO_MEM);
  assign ramLast    = (ramCntR == RAM_LAST);

`ifdef BUS_TIMEOUT_EN
  localparam logic [WIDTH-1:0] TO_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] toCntR;

  // Cycles spent waiting for io_ack; restarts on every entry into IO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      toCntR <= ZERO_W;
    end else if (stateR == IO) begin
      toCntR <= toCntR + ONE_W;
    end else begin
      toCntR <= ZERO_W;
    end
  end

  assign toExpire = (stateR == IO) && (toCntR == TO_LAST);
`else
  assign toExpire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNxt;
    end
  end

  // Next-state decode; an ack in the expiry cycle still finishes without error.
  always_comb begin
    stateNxt = stateR;
    case (stateR)
      IDLE: begin
        if (req_valid) begin
          if (protHit) begin
            stateNxt = DONE;
          end else if (ioHit) begin
            stateNxt = IO;
          end else begin
            stateNxt = RAM;
          end
        end else begin
          stateNxt = IDLE;
        end
      end
      RAM: begin
        if (ramLast) begin
          stateNxt = DONE;
        end else begin
          stateNxt = RAM;
        end
      end
      IO: begin
        if (io_ack || toExpire) begin
          stateNxt = DONE;
        end else begin
          stateNxt = IO;
        end
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Request latch, RAM beat counter, error flag and returned load data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addrR   <= ZERO_W;
      wdataR  <= ZERO_W;
      writeR  <= 1'b0;
      errR    <= 1'b0;
      rdataR  <= ZERO_W;
      ramCntR <= 3'd0;
    end else begin
      case (stateR)
        IDLE: begin
          if (req_valid) begin
            addrR   <= address;
            wdataR  <= wdata;
            writeR  <= req_write;
            errR    <= protHit;
            ramCntR <= 3'd0;
          end
        end
        RAM: begin
          ramCntR <= ramCntR + 3'd1;
          if (ramLast && !writeR) begin
            rdataR <= ram_rdata;
          end
        end
        IO: begin
          if (io_ack) begin
            if (!writeR) begin
              rdataR <= io_rdata;
            end
          end else if (toExpire) begin
            errR <= 1'b1;
            if (!writeR) begin
              rdataR <= ONES_W;
            end
          end
        end
        DONE:    errR <= 1'b0;
        default: errR <= 1'b0;
      endcase
    end
  end

  // Port outputs decode from registered state and the request latch only.
  assign req_done  = (stateR == DONE);
  assign bus_err   = (stateR == DONE) && errR;
  assign rdata     = rdataR;
  assign ram_en    = (stateR == RAM);
  assign ram_we    = (stateR == RAM) && writeR;
  assign ram_addr  = (stateR == RAM) ? addrR  : ZERO_W;
  assign ram_wdata = (stateR == RAM) ? wdataR : ZERO_W;
  assign io_req    = (stateR == IO);
  assign io_we     = (stateR == IO) && writeR;
  assign io_addr   = (stateR == IO) ? addrR  : ZERO_W;
  assign io_wdata  = (stateR == IO) ? wdataR : ZERO_W;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vector table, random requests against a
// behavioural model, timeout cases (with BUS_TIMEOUT_EN) and a mid-access reset.
module tb_mem_bus_ctrl;

  localparam int          LAT_TB = 2;
  localparam int          TO_TB  = 16;
  localparam logic [15:0] PROT_HI = 16'h5FFF;
  localparam logic [15:0] IO_LO   = 16'hCFFD;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [15:0] address;
  logic [15:0] wdata;
  logic        req_done;
  logic [15:0] rdata;
  logic        bus_err;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        io_req;
  logic        io_we;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        io_ack;

  int nPass;
  int nChecks;
  logic [15:0] mdlRdata;

  mem_bus_ctrl #(.WIDTH(16), .RAM_LAT(LAT_TB), .TIMEOUT(TO_TB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .address(address), .wdata(wdata), .req_done(req_done), .rdata(rdata),
    .bus_err(bus_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .io_req(io_req), .io_we(io_we),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] wd;
    int          ackD;
    logic [15:0] ioRd;
    logic [15:0] ramRd;
    int          eLat;
    int          eRam;
    int          eIo;
    logic        eErr;
    logic [15:0] eRd;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One request from the IDLE cycle to its done pulse, with the responses supplied by the bench.
  task automatic runReq(input string nm, input logic w, input logic [15:0] a, input logic [15:0] wd,
                        input int ackD, input logic [15:0] ioRd, input logic [15:0] ramRd,
                        input int eLat, input int eRam, input int eIo, input logic eErr,
                        input logic [15:0] eRd, input bit junk);
    int   k;
    int   nRam;
    int   nIo;
    bit   portOk;
    bit   done;
    logic gotErr;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; address = a; wdata = wd;
    ram_rdata = ramRd; io_rdata = ioRd; io_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0; nRam = 0; nIo = 0; portOk = 1'b1; done = 1'b0; gotErr = 1'b0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (ram_en) begin
        nRam++;
        if (ram_addr !== a || ram_we !== w || (w && ram_wdata !== wd)) portOk = 1'b0;
      end
      if (io_req) begin
        nIo++;
        if (io_addr !== a || io_we !== w || (w && io_wdata !== wd)) portOk = 1'b0;
      end
      if (ram_en && io_req) portOk = 1'b0;
      if (req_done) begin
        done   = 1'b1;
        gotErr = bus_err;
      end else if (bus_err) begin
        portOk = 1'b0;
      end
      io_ack = io_req && (nIo == ackD);
      if (junk) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        address   = 16'($urandom);
        wdata     = 16'($urandom);
      end
    end
    io_ack = 1'b0;
    req_valid = 1'b0;
    chk({nm, " latency"}, k, eLat);
    chk({nm, " ram_en cycles"}, nRam, eRam);
    chk({nm, " io_req cycles"}, nIo, eIo);
    chk({nm, " bus_err"}, gotErr, eErr);
    chk({nm, " rdata"}, rdata, eRd);
    chk({nm, " port signals"}, portOk, 1'b1);
  endtask

  // Reference behaviour: region rules and latency formulas, with load data tracked in mdlRdata.
  task automatic modelReq(input logic w, input logic [15:0] a, input int ackD,
                          input logic [15:0] ioRd, input logic [15:0] ramRd,
                          output int eLat, output int eRam, output int eIo, output logic eErr);
    bit prot;
    bit isIo;
    bit timedOut;
    prot = w && (a <= PROT_HI);
    isIo = (a >= IO_LO);
    timedOut = 1'b0;
`ifdef BUS_TIMEOUT_EN
    timedOut = (ackD > TO_TB);
`endif
    eRam = 0; eIo = 0; eErr = 1'b0;
    if (prot) begin
      eLat = 1;
      eErr = 1'b1;
    end else if (isIo && timedOut) begin
      eLat = TO_TB + 1;
      eIo  = TO_TB;
      eErr = 1'b1;
      if (!w) mdlRdata = 16'hFFFF;
    end else if (isIo) begin
      eLat = ackD + 1;
      eIo  = ackD;
      if (!w) mdlRdata = ioRd;
    end else begin
      eLat = LAT_TB + 1;
      eRam = LAT_TB;
      if (!w) mdlRdata = ramRd;
    end
  endtask

  logic        rw;
  logic [15:0] ra;
  logic [15:0] rwd;
  logic [15:0] rio;
  logic [15:0] rram;
  int          rack;
  int          mLat;
  int          mRam;
  int          mIo;
  logic        mErr;
  bit          sawDone;

  initial begin
    nPass = 0; nChecks = 0; mdlRdata = 16'h0000;
    reset = 1'b0; req_valid = 1'b1; req_write = 1'b0; address = 16'h7000; wdata = 16'h0000;
    ram_rdata = 16'h1357; io_rdata = 16'h2468; io_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset req_done", req_done, 1'b0);
    chk("reset ram_en", ram_en, 1'b0);
    chk("reset io_req", io_req, 1'b0);
    chk("reset rdata", rdata, 16'h0000);
    chk("reset bus_err", bus_err, 1'b0);
    reset = 1'b1; req_valid = 1'b0;

    //         w     addr      wdata     ack ioRd      ramRd     lat ram io err   rdata
    tbl[0] = '{1'b0, 16'h7000, 16'h0000, 0, 16'h0000, 16'hBEEF, 3, 2, 0, 1'b0, 16'hBEEF};
    tbl[1] = '{1'b1, 16'h5FFF, 16'h1234, 0, 16'h0000, 16'h0000, 1, 0, 0, 1'b1, 16'hBEEF};
    tbl[2] = '{1'b1, 16'h6000, 16'h5678, 0, 16'h0000, 16'h0000, 3, 2, 0, 1'b0, 16'hBEEF};
    tbl[3] = '{1'b0, 16'hCFFD, 16'h0000, 5, 16'h00A5, 16'h0000, 6, 0, 5, 1'b0, 16'h00A5};
    tbl[4] = '{1'b0, 16'hCFFC, 16'h0000, 0, 16'h0000, 16'h1111, 3, 2, 0, 1'b0, 16'h1111};
    tbl[5] = '{1'b1, 16'hFFFF, 16'hAAAA, 2, 16'h9999, 16'h0000, 3, 0, 2, 1'b0, 16'h1111};
    tbl[6] = '{1'b0, 16'hFFFF, 16'h0000, 1, 16'h2222, 16'h0000, 2, 0, 1, 1'b0, 16'h2222};
    tbl[7] = '{1'b1, 16'h0000, 16'h4444, 0, 16'h0000, 16'h0000, 1, 0, 0, 1'b1, 16'h2222};
    tbl[8] = '{1'b0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h3333, 3, 2, 0, 1'b0, 16'h3333};
    for (int i = 0; i < 9; i++) begin
      runReq($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].ackD, tbl[i].ioRd,
             tbl[i].ramRd, tbl[i].eLat, tbl[i].eRam, tbl[i].eIo, tbl[i].eErr, tbl[i].eRd, 1'b0);
    end
    mdlRdata = 16'h3333;

    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       ra = 16'($urandom);
        1:       ra = PROT_HI + 16'($urandom_range(0, 2)) - 16'd1;
        2:       ra = IO_LO + 16'($urandom_range(0, 2)) - 16'd1;
        3:       ra = 16'hFFFF;
        4:       ra = 16'($urandom_range(0, 3));
        default: ra = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
      endcase
      rwd  = 16'($urandom);
      rio  = 16'($urandom);
      rram = 16'($urandom);
      rack = $urandom_range(1, 8);
      modelReq(rw, ra, rack, rio, rram, mLat, mRam, mIo, mErr);
      runReq($sformatf("rnd%0d", i), rw, ra, rwd, rack, rio, rram, mLat, mRam, mIo, mErr, mdlRdata, 1'b1);
    end

`ifdef BUS_TIMEOUT_EN
    modelReq(1'b0, 16'hCFFD, 1000, 16'h0BAD, 16'h0000, mLat, mRam, mIo, mErr);
    runReq("timeout read", 1'b0, 16'hCFFD, 16'h0000, 1000, 16'h0BAD, 16'h0000, 17, 0, 16, 1'b1, 16'hFFFF, 1'b0);
    runReq("ack at expiry", 1'b0, 16'hD000, 16'h0000, 16, 16'h5A5A, 16'h0000, 17, 0, 16, 1'b0, 16'h5A5A, 1'b0);
    runReq("timeout write", 1'b1, 16'hE000, 16'h7777, 1000, 16'h0000, 16'h0000, 17, 0, 16, 1'b1, 16'h5A5A, 1'b0);
    mdlRdata = 16'h5A5A;
`endif

    // Reset in the middle of an IO wait abandons the access.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; address = 16'hE000; io_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("io_req before reset", io_req, 1'b1);
    #2 reset = 1'b0;
    #1 chk("io_req async drop", io_req, 1'b0);
    sawDone = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (req_done) sawDone = 1'b1;
    end
    chk("no done after reset", sawDone, 1'b0);
    chk("rdata after reset", rdata, 16'h0000);
    reset = 1'b1;
    mdlRdata = 16'h0000;
    modelReq(1'b0, 16'hE000, 3, 16'hC0DE, 16'h0000, mLat, mRam, mIo, mErr);
    runReq("after reset io", 1'b0, 16'hE000, 16'h0000, 3, 16'hC0DE, 16'h0000, mLat, mRam, mIo, mErr, mdlRdata, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
